// File: rtl/apb5_arb_pkg.sv
// Shared types for the APB5 requester arbiter: FSM states, registered request payload, owner width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Payload fields are sized for the largest supported configuration (32-bit address/data, 16 requesters);
// the top module zero-extends into them and slices back out to its configured widths.
package apb5_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int ARB_ADDR_MAX  = 32;
  localparam int ARB_DATA_MAX  = 32;
  localparam int ARB_STRB_MAX  = 4;
  localparam int ARB_OWNER_MAX = 4;

  typedef struct packed {
    logic [ARB_ADDR_MAX-1:0]  addr;
    logic                     write;
    logic [ARB_DATA_MAX-1:0]  wdata;
    logic [ARB_STRB_MAX-1:0]  strb;
    logic [2:0]               prot;
    logic                     nse;
    logic [ARB_OWNER_MAX-1:0] owner;
  } req_t;

  // Width of a binary requester index; at least one bit.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb5_rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping, for the first set request.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is taken this cycle.
// Ports: req (request vector), last_grant (index of previous winner), grant (one-hot), grant_idx (binary), any (a request exists).
module apb5_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [OW-1:0]      grant_idx,
  output logic               any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Offsets 1..NUM_REQ cover every requester once, ending on last_grant itself.
    for (int i = 1; i <= NUM_REQ; i++) begin
      automatic int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb5_requester_arbiter.sv
// Shares one APB5 requester port among NUM_REQ local requesters with round-robin arbitration and optional ACCESS timeout.
// Latency: req_valid in IDLE at cycle 0 -> PSEL cycle 1, PENABLE cycle 2, rsp_valid earliest cycle 3; 2 cycles per zero-wait transfer back-to-back.
// Backpressure: req_ready is a combinational one-hot accept, given only in IDLE or in the completing ACCESS cycle; PREADY stretches ACCESS.
// Ports: PCLK/PRESET (async active-high); req_* per-requester flattened payloads; rsp_valid/rsp_rdata/rsp_err completion;
// P* APB5 requester signals. Optional macro APB5_ARB_WAKEUP_EN turns PWAKEUP into a live register (otherwise tied 0).
module apb5_requester_arbiter
  import apb5_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 0
) (
  input  logic                               PCLK,
  input  logic                               PRESET,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
  input  logic [NUM_REQ*3-1:0]               req_prot,
  input  logic [NUM_REQ-1:0]                 req_nse,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_err,
  output logic                               PSEL,
  output logic                               PENABLE,
  output logic                               PWRITE,
  output logic                               PNSE,
  output logic [ADDR_WIDTH-1:0]              PADDR,
  output logic [DATA_WIDTH-1:0]              PWDATA,
  output logic [DATA_WIDTH/8-1:0]            PSTRB,
  output logic [2:0]                         PPROT,
  output logic                               PWAKEUP,
  input  logic [DATA_WIDTH-1:0]              PRDATA,
  input  logic                               PREADY,
  input  logic                               PSLVERR
);

  localparam int OW = owner_width(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [OW-1:0]       last_grant_q;
  logic [CW-1:0]       wait_cnt_q;
  req_t                pay_q, pay_d;

  logic [NUM_REQ-1:0]  grant;
  logic [OW-1:0]       grant_idx;
  logic                any_req;
  logic                timeout_hit;
  logic                xfer_done;
  logic                arb_cycle;

  apb5_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  // Timeout fires on the ACCESS cycle where TIMEOUT wait cycles have already elapsed and PREADY is still low,
  // so ACCESS lasts TIMEOUT+1 cycles. A PREADY on that same cycle wins as a normal completion.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !PREADY && (wait_cnt_q == CW'(TIMEOUT));
  assign xfer_done   = (state_q == ACCESS) && (PREADY || timeout_hit);
  assign arb_cycle   = (state_q == IDLE) || xfer_done;

  assign req_ready = (!PRESET && arb_cycle) ? grant : '0;

  // Payload of the current winner; read data fields are forced to zero so PWDATA/PSTRB read as 0 on reads.
  always_comb begin
    pay_d       = '0;
    pay_d.addr  = ARB_ADDR_MAX'(req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH]);
    pay_d.write = req_write[grant_idx];
    if (req_write[grant_idx]) begin
      pay_d.wdata = ARB_DATA_MAX'(req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH]);
      pay_d.strb  = ARB_STRB_MAX'(req_strb[grant_idx*SW +: SW]);
    end
    pay_d.prot  = req_prot[grant_idx*3 +: 3];
    pay_d.nse   = req_nse[grant_idx];
    pay_d.owner = ARB_OWNER_MAX'(grant_idx);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = any_req ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= OW'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      pay_q        <= '0;
    end else begin
      state_q <= state_d;
      if (arb_cycle && any_req) begin
        last_grant_q <= grant_idx;
        pay_q        <= pay_d;
      end
      if (state_q == SETUP) begin
        wait_cnt_q <= '0;
      end else if ((TIMEOUT != 0) && (state_q == ACCESS) && !PREADY && (wait_cnt_q != CW'(TIMEOUT))) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
      end
    end
  end

  // Completion is reported one cycle after the finishing ACCESS cycle; response fields are zero when idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (xfer_done) begin
        rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pay_q.owner[OW-1:0];
        rsp_err   <= timeout_hit || PSLVERR;
        if (!timeout_hit && !pay_q.write) rsp_rdata <= PRDATA;
      end
    end
  end

  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = pay_q.write;
  assign PNSE    = pay_q.nse;
  assign PADDR   = pay_q.addr[ADDR_WIDTH-1:0];
  assign PWDATA  = pay_q.wdata[DATA_WIDTH-1:0];
  assign PSTRB   = pay_q.strb[SW-1:0];
  assign PPROT   = pay_q.prot;

  // Upper payload bits beyond the configured widths are intentionally dropped.
  logic unused_pay;
  assign unused_pay = ^pay_q;

`ifdef APB5_ARB_WAKEUP_EN
  // Raised the cycle after any request appears (same cycle as PSEL); dropped one cycle after the bus goes quiet.
  logic pwakeup_q;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) pwakeup_q <= 1'b0;
    else        pwakeup_q <= (|req_valid) || (state_q != IDLE);
  end
  assign PWAKEUP = pwakeup_q;
`else
  assign PWAKEUP = 1'b0;
`endif

endmodule

// File: tb/tb_apb5_requester_arbiter.sv
// Self-checking bench: random requesters and a planned completer; a transaction-level model predicts grants,
// bus phases and responses; a separate monitor pops expected responses whenever rsp_valid is seen.
// Run length is a few thousand cycles.
module tb_apb5_requester_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 5;

  logic            PCLK, PRESET;
  logic [N-1:0]    req_valid, req_ready, req_write, req_nse, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_strb;
  logic [N*3-1:0]  req_prot;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PNSE, PWAKEUP, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;
  logic [0:0]      PSTRB;
  logic [2:0]      PPROT;

  apb5_requester_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .req_nse(req_nse),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PNSE(PNSE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PWAKEUP(PWAKEUP),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    int         owner;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       strb;
    logic [2:0] prot;
    logic       nse;
    int         waits;
    logic [7:0] prdata;
    logic       err;
  } plan_t;

  typedef struct {
    int         owner;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } rsp_t;

  rsp_t  exp_q[$];
  plan_t cur;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int setup_cyc, comp_cyc, last_w, single_left;
  logic exp_wake;

  logic [N-1:0] active, granted;
  logic [7:0]   r_addr[N];
  logic [7:0]   r_wdata[N];
  logic         r_wr[N];
  logic         r_strb[N];
  logic [2:0]   r_prot[N];
  logic         r_nse[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    active    = '0;
    granted   = '0;
    setup_cyc = -100;
    comp_cyc  = -100;
    last_w    = N - 1;
    exp_wake  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {PSEL, PENABLE, PWRITE, PNSE, PADDR, PWDATA, PSTRB, PPROT, PWAKEUP,
               rsp_valid, rsp_rdata, rsp_err, req_ready}, 64'h0);
  endtask

  // Modes: 0 random traffic, 1 all requesters saturated with zero waits, 2 single read 0x3C/0xA5,
  // 3 single write strb 1 with 3 waits and PSLVERR, 4 single read with PREADY stuck low, 5 drain (no new requests).
  task automatic step(input int mode);
    plan_t        p;
    logic [N-1:0] vec, exp_rdy;
    int           w, k, len;
    logic         arb, exp_psel, exp_pen, start, tmo;

    @(posedge PCLK); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        active[i]  = 1'b0;
        granted[i] = 1'b0;
      end
      if (active[i] && mode == 0 && $urandom_range(0, 15) == 0) active[i] = 1'b0;
      if (!active[i]) begin
        case (mode)
          0:       start = ($urandom_range(0, 2) == 0);
          1:       start = 1'b1;
          2, 3, 4: start = (i == 0) && (single_left > 0);
          default: start = 1'b0;
        endcase
        if (start) begin
          if (mode >= 2 && mode <= 4) single_left--;
          active[i]  = 1'b1;
          r_wr[i]    = 1'($urandom);
          r_addr[i]  = 8'($urandom);
          r_wdata[i] = 8'($urandom);
          r_strb[i]  = 1'($urandom);
          r_prot[i]  = 3'($urandom);
          r_nse[i]   = 1'($urandom);
          if (mode == 2) begin r_wr[i] = 1'b0; r_addr[i] = 8'h3C; end
          if (mode == 3) begin r_wr[i] = 1'b1; r_strb[i] = 1'b1; end
          if (mode == 4) r_wr[i] = 1'b0;
        end
      end
      req_valid[i]          = active[i];
      req_write[i]          = r_wr[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
      req_strb[i]           = r_strb[i];
      req_prot[i*3 +: 3]    = r_prot[i];
      req_nse[i]            = r_nse[i];
    end

    @(negedge PCLK);
    exp_psel = (cyc >= setup_cyc) && (cyc <= comp_cyc);
    exp_pen  = (cyc > setup_cyc) && (cyc <= comp_cyc);
    if (exp_pen) begin
      k       = cyc - setup_cyc - 1;
      PREADY  = (k >= cur.waits);
      PRDATA  = PREADY ? cur.prdata : 8'($urandom);
      PSLVERR = PREADY ? cur.err : 1'($urandom);
    end else begin
      PREADY  = 1'($urandom);
      PRDATA  = 8'($urandom);
      PSLVERR = 1'($urandom);
    end
    #1;
    chk("psel", PSEL, exp_psel);
    chk("penable", PENABLE, exp_pen);
    if (exp_psel)
      chk("apb_payload", {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE},
          {cur.addr, cur.wr, (cur.wr ? cur.wdata : 8'h00), (cur.wr ? cur.strb : 1'b0), cur.prot, cur.nse});
    chk("pwakeup", PWAKEUP, exp_wake);

    // Arbitration happens whenever no transfer is outstanding or the current one finishes this cycle.
    arb     = (cyc >= comp_cyc);
    vec     = req_valid;
    exp_rdy = '0;
    w       = -1;
    if (arb) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (last_w + j) % N;
        if (w < 0 && vec[c]) w = c;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);

    if (w >= 0) begin
      granted[w] = 1'b1;
      last_w     = w;
      p.owner    = w;
      p.wr       = r_wr[w];
      p.addr     = r_addr[w];
      p.wdata    = r_wdata[w];
      p.strb     = r_strb[w];
      p.prot     = r_prot[w];
      p.nse      = r_nse[w];
      p.prdata   = 8'($urandom);
      p.err      = ($urandom_range(0, 3) == 0);
      case (mode)
        1:       p.waits = 0;
        2:       begin p.waits = 0; p.prdata = 8'hA5; p.err = 1'b0; end
        3:       begin p.waits = 3; p.err = 1'b1; end
        4:       p.waits = 40;
        default: p.waits = $urandom_range(0, 7);
      endcase
      cur       = p;
      tmo       = (p.waits > TMO);
      len       = tmo ? TMO + 1 : p.waits + 1;
      setup_cyc = cyc + 1;
      comp_cyc  = setup_cyc + len;
      exp_q.push_back('{owner: w, rdata: ((tmo || p.wr) ? 8'h00 : p.prdata), err: (tmo ? 1'b1 : p.err), cyc: comp_cyc + 1});
    end
`ifdef APB5_ARB_WAKEUP_EN
    exp_wake = (|vec) || exp_psel;
`else
    exp_wake = 1'b0;
`endif
  endtask

  // Response monitor, decoupled from stimulus.
  initial begin
    rsp_t         e;
    logic [N-1:0] ev;
    forever begin
      @(negedge PCLK); #2;
      if (!PRESET && rsp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid %0h expected none (cycle %0d)", rsp_valid, cyc);
        end else begin
          e  = exp_q.pop_front();
          ev = '0;
          ev[e.owner] = 1'b1;
          chk("rsp_valid", rsp_valid, ev);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int b;
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; req_nse = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_wr[i] = 1'b0; r_strb[i] = 1'b0; r_prot[i] = '0; r_nse[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    check_reset_outputs("reset_outputs");
    PRESET = 1'b0;

    single_left = 1; repeat (12) step(2);
    single_left = 1; repeat (16) step(3);
    single_left = 1; repeat (20) step(4);
    repeat (40) step(1);
    repeat (1500) step(0);

    // Reset in the middle of a stretched ACCESS: in-flight transfer must vanish without a response.
    b = 0;
    while (!(cyc > setup_cyc && cyc < comp_cyc) && b < 300) begin
      step(0);
      b++;
    end
    if (b >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL reset_window: got no ACCESS window within %0d cycles expected one", b);
    end
    #2;
    PRESET    = 1'b1;
    req_valid = '0;
    model_reset();
    #1;
    check_reset_outputs("midreset_outputs");
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    repeat (30) step(1);
    repeat (500) step(0);

    b = 0;
    while ((exp_q.size() != 0 || active != '0) && b < 200) begin
      step(5);
      b++;
    end
    repeat (3) step(5);
    #5;
    chk("rsp_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb5_requester_arbiter.md
# apb5_requester_arbiter

Shares one APB5 requester (manager) port among NUM_REQ local requesters. It performs round-robin arbitration, sequences the APB SETUP/ACCESS phases, enforces an optional wait-state timeout and routes PRDATA/PSLVERR back to the winning requester. It sits between the VIP's sequence-driven agents, or any RTL masters, and the APB5 completer side of the b2b bench.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- ADDR_WIDTH, 8: PADDR width.
- DATA_WIDTH, 8: PWDATA/PRDATA width (8/16/32).
- TIMEOUT, 0: ACCESS wait-state limit in cycles; 0 disables.

Ports:
- PCLK  in  1  sole clock.
- PRESET  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot accept; combinational.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened address, requester i at slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  write strobes.
- req_prot  in  NUM_REQ*3  PPROT value.
- req_nse  in  NUM_REQ  PNSE value.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  PSLVERR or timeout.
- PSEL, PENABLE, PWRITE, PNSE  out  1 each  APB5 control.
- PADDR  out  ADDR_WIDTH; PWDATA out DATA_WIDTH; PSTRB out DATA_WIDTH/8; PPROT out 3.
- PWAKEUP  out  1  APB5 wake-up.
- PRDATA  in  DATA_WIDTH; PREADY in 1; PSLVERR in 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS. The reset state is IDLE.
- Arbitration cycle: state IDLE, or state ACCESS with the transfer completing. A completion is PREADY=1 or a timeout.
- In an arbitration cycle with any req_valid:
  - Round-robin pick, searching from last_grant+1 upward and wrapping.
  - req_ready[winner]=1 that cycle.
  - Winner payload registered; last_grant updated; next state SETUP.
- With no req_valid in an arbitration cycle, the next state is IDLE.
- SETUP: PSEL=1, PENABLE=0; the next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1. The FSM stays in ACCESS while PREADY=0 and no timeout has occurred.
- Completion, registered into the next cycle:
  - rsp_valid[owner]=1 for exactly one cycle.
  - rsp_rdata = PRDATA on a read, 0 on a write.
  - rsp_err = PSLVERR.
- PSLVERR is sampled only when PREADY=1.
- Timeout:
  - wait_cnt counts ACCESS cycles with PREADY=0 and clears in SETUP.
  - When wait_cnt reaches TIMEOUT, the transfer completes with rsp_err=1 and rsp_rdata=0.
  - PSEL/PENABLE then follow the next state.
- Read transfers drive PSTRB=0 and PWDATA=0. APB signals hold their values throughout SETUP/ACCESS.
- In IDLE, PSEL/PENABLE=0 and the address/data outputs hold their last value.
- Requesters hold req_valid and payload stable until req_ready. Deasserting req_valid before req_ready is allowed; the request is then simply not granted.
- Simultaneous requests: exactly one grant per arbitration cycle. No requester waits more than NUM_REQ-1 grants.

## Timing
- Reset, asynchronous: all outputs 0, state IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), wait_cnt=0.
- A transfer in flight at reset is dropped and produces no rsp_valid.
- Latency from req_valid in IDLE, cycle 0: PSEL cycle 1, PENABLE cycle 2, earliest rsp_valid cycle 3.
- Back-to-back transfers: the next SETUP follows the completing ACCESS cycle directly, giving 2 APB cycles per zero-wait transfer.
- A timeout with TIMEOUT=T ends ACCESS after T+1 cycles with PREADY=0.

## Configuration
- Macro: APB5_ARB_WAKEUP_EN.
- Defined: PWAKEUP is a register.
  - Set in any cycle where req_valid≠0 or state≠IDLE, so it is high no later than PSEL.
  - Cleared the cycle after state=IDLE with req_valid=0.
- Undefined: PWAKEUP is tied to 0 and no wake-up logic is generated.

## Structure
- Package apb5_arb_pkg:
  - state enum (IDLE/SETUP/ACCESS).
  - Registered-request struct: addr, write, wdata, strb, prot, nse, owner index.
  - Function clog2-based owner width.
- Sub-module apb5_rr_arbiter: combinational round-robin pick from (req vector, last_grant), producing a one-hot grant and a binary index.

## Test plan
- Single read, req 0, addr 0x3C, PREADY=1 in first ACCESS, PRDATA=0xA5 -> PSEL cycles 1–2, rsp_valid[0] cycle 3, rsp_rdata=0xA5, rsp_err=0.
- All 4 req_valid held high from reset release -> grants in order 0,1,2,3,0; PSEL continuously high, PENABLE toggling every cycle.
- Write, strb 0x1, PREADY low for 3 ACCESS cycles then high with PSLVERR=1 -> ACCESS lasts 4 cycles, rsp_err=1, PSTRB=0x1 throughout.
- TIMEOUT=5, PREADY stuck low -> ACCESS held 6 cycles, rsp_valid with rsp_err=1, rsp_rdata=0, then IDLE with PSEL=0.
- PRESET asserted mid-ACCESS -> all outputs 0 immediately; no rsp_valid; after release, req 0 is granted first.
- With APB5_ARB_WAKEUP_EN defined: PWAKEUP rises with PSEL and falls 1 cycle after the last completion. With it undefined, PWAKEUP stays 0.
